// File: rtl/controlador_memoria_dados.sv
// rtl/controlador_memoria_dados.sv - access sequencer for the 16x16 data memory (load/store/fill/copy)
module controlador_memoria_dados #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [ADDR_W:0]   Count,
  input  logic [DATA_W-1:0] WData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RData,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_Din,
  input  logic [DATA_W-1:0] mem_Q
);

  typedef enum logic [3:0] {
    IDLE, LD_RD, LD_WAIT, ST_WR, FILL_WR, CP_RD, CP_WAIT, CP_WR, FIN
  } state_t;

  localparam logic [ADDR_W:0]   MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   count_sat;

  // Word counts beyond the memory depth behave as a full sweep
  always_comb begin
    count_sat = Count;
    if (Count > MAX_CNT) count_sat = MAX_CNT;
  end

  // Command sequencer: every output is a register updated here
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      RData       <= '0;
      mem_wren    <= 1'b0;
      mem_Address <= '0;
      mem_Din     <= '0;
      src         <= '0;
      dst         <= '0;
      remaining   <= '0;
    end else begin
      case (state)
        // FIN is the Done cycle; it accepts a new command exactly like IDLE
        IDLE, FIN: begin
          Done     <= 1'b0;
          Busy     <= 1'b0;
          mem_wren <= 1'b0;
          state    <= IDLE;
          if (Start) begin
            case (Op)
              2'b00: begin
                Busy        <= 1'b1;
                mem_Address <= AddrA;
                state       <= LD_RD;
              end
              2'b01: begin
                Busy        <= 1'b1;
                mem_wren    <= 1'b1;
                mem_Address <= AddrA;
                mem_Din     <= WData;
                state       <= ST_WR;
              end
              2'b10: begin
                if (count_sat == '0) begin
                  Done  <= 1'b1;
                  state <= FIN;
                end else begin
                  Busy        <= 1'b1;
                  mem_wren    <= 1'b1;
                  mem_Address <= AddrA;
                  mem_Din     <= WData;
                  remaining   <= count_sat;
                  state       <= FILL_WR;
                end
              end
              default: begin
                if (count_sat == '0) begin
                  Done  <= 1'b1;
                  state <= FIN;
                end else begin
                  Busy        <= 1'b1;
                  mem_Address <= AddrA;
                  src         <= AddrA;
                  dst         <= AddrB;
                  remaining   <= count_sat;
                  state       <= CP_RD;
                end
              end
            endcase
          end
        end
        LD_RD: state <= LD_WAIT;
        LD_WAIT: begin
          RData <= mem_Q;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= FIN;
        end
        ST_WR: begin
          mem_wren <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          state    <= FIN;
        end
        FILL_WR: begin
          if (remaining == CNT_ONE) begin
            mem_wren <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= FIN;
          end else begin
            mem_Address <= mem_Address + ADDR_ONE;
            remaining   <= remaining - CNT_ONE;
          end
        end
        CP_RD: state <= CP_WAIT;
        CP_WAIT: begin
          mem_Din     <= mem_Q;
          RData       <= mem_Q;
          mem_wren    <= 1'b1;
          mem_Address <= dst;
          state       <= CP_WR;
        end
        CP_WR: begin
          mem_wren <= 1'b0;
          if (remaining == CNT_ONE) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            src         <= src + ADDR_ONE;
            dst         <= dst + ADDR_ONE;
            mem_Address <= src + ADDR_ONE;
            remaining   <= remaining - CNT_ONE;
            state       <= CP_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/controlador_memoria_dados.md
Name: controlador_memoria_dados

Overview:
Access sequencer that drives the 16x16 data memory's port (wren, Address, Din, Q; one-cycle synchronous read latency) on behalf of the datapath. It accepts one command per Start pulse: single load, single store, block fill, or block copy. It generates the exact cycle-by-cycle memory access pattern and returns read data with a one-cycle Done pulse. It sits between the control unit / register file and the data memory.

Parameters:
ADDR_W, 4, memory address width (depth 2**ADDR_W)
DATA_W, 16, data word width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  command strobe; sampled only in IDLE
Op  in  2  00 load, 01 store, 10 fill, 11 copy
AddrA  in  ADDR_W  load/store address; fill base; copy source base
AddrB  in  ADDR_W  copy destination base (ignored otherwise)
Count  in  ADDR_W+1  fill/copy word count; 0 = no-op; >16 saturates to 16
WData  in  DATA_W  store/fill data
Busy  out  1  command in progress
Done  out  1  one-cycle completion pulse
RData  out  DATA_W  last word read (load result / last copied word)
mem_wren  out  1  to memory wren
mem_Address  out  ADDR_W  to memory Address
mem_Din  out  DATA_W  to memory Din
mem_Q  in  DATA_W  from memory Q

Behaviour:
- One clock, Clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: Busy=0, Done=0, RData=0, mem_wren=0, mem_Address=0, mem_Din=0, state=IDLE.
- Reset mid-command aborts immediately. No further writes occur; memory keeps whatever was already written.
- States: IDLE, LD_RD, LD_WAIT, ST_WR, FILL_WR, CP_RD, CP_WAIT, CP_WR, FIN.
- Timing notation: "cycle n" is the n-th cycle after the edge that samples Start=1 in IDLE.
- Command fields Op/AddrA/AddrB/Count/WData are latched at that edge. Later input changes have no effect.
- Busy is 1 from cycle 1 through the cycle before Done. Busy is 0 in the Done cycle.
- Start is ignored while Busy=1. Start=1 in the Done cycle is accepted, giving back-to-back commands.
- mem_wren=1 only in write cycles. In all other cycles mem_Address and mem_Din hold their last values.
- Load: cycle 1 drives addr=AddrA, wren=0. mem_Q is sampled at the end of cycle 2 into RData. Done=1 in cycle 3 with RData valid.
- Store: cycle 1 drives wren=1, addr=AddrA, Din=WData. Done in cycle 2. RData is unchanged.
- Fill N: cycles 1..N drive wren=1, addr=AddrA+i (i=0..N-1), Din=WData. Done in cycle N+1. RData is unchanged.
- Copy N, word i (i=0..N-1):
  - cycle 3i+1: addr=AddrA+i, wren=0
  - cycle 3i+2: wren=0, address held
  - end of cycle 3i+2: mem_Q is latched into mem_Din and RData
  - cycle 3i+3: wren=1, addr=AddrB+i
  - Done in cycle 3N+1.
- Addresses increment modulo 2**ADDR_W and wrap 15->0 silently.
- Copy is strictly sequential in ascending order. When ranges overlap with AddrB>AddrA, already-written words are re-read; this is the defined result.
- Count=0 for fill/copy: no memory access; Done in cycle 1.
- Count values 17..31 behave exactly as 16.
- Count is ignored for load/store.
- Done is exactly one cycle wide and never asserts without a preceding accepted Start.

Test Plan:
- Reset mid-fill: Reset asserted asynchronously during cycle 3 of fill Count=8 -> outputs clear immediately, no wren after reset, memory[0..1] written, the rest unchanged.
- Store then load: store AddrA=5 WData=0xBEEF (Done in cycle 2, wren high exactly 1 cycle), then load AddrA=5 -> Done in cycle 3, RData=0xBEEF; load AddrA=6 after reset -> RData=0x0000.
- Fill wrap: fill AddrA=14, Count=4, WData=0x1234 -> writes addresses 14,15,0,1 in cycles 1-4, Done in cycle 5; address 2 stays 0.
- Copy overlap: preload mem[0..3]=1,2,3,4; copy AddrA=0, AddrB=1, Count=3 -> Done in cycle 10, mem[0..3]=1,1,1,1, RData=1.
- Count edge cases: fill Count=0 -> Done in cycle 1, no wren; fill Count=20 -> exactly 16 writes, Done in cycle 17.
- Start handling: Start held high during a copy -> ignored until the Done cycle; a Start in the Done cycle launches the next command in the following cycle with no gap.
